// File: rtl/prog_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_ram_loader
// Purpose  : Loads a 16 x 8 program RAM from a byte stream. The stream is
//            16 program bytes in address order followed by one checksum byte.
//            The image is accepted only when the 8-bit sum of all 17 bytes is
//            zero. The CPU is held in reset while an image is in flight or
//            has been rejected.
// Ports    : clk_i          - single clock, rising edge
//            n_reset_i      - asynchronous active-low reset
//            load_start_i   - one-cycle request to begin a new image
//            in_valid_i     - in_data_i carries a valid byte
//            in_data_i[7:0] - image byte
//            in_ready_o     - loader accepts a byte this cycle
//            addr_i[3:0]    - CPU instruction-fetch address
//            data_o[7:0]    - instruction word at addr_i (combinational)
//            cpu_n_reset_o  - active-low CPU hold
//            busy_o         - loading or checking
//            done_o         - image accepted
//            err_o          - checksum mismatch
// Revision : 1.0 - initial release
// ============================================================================
module prog_ram_loader (
  input  logic       clk_i,
  input  logic       n_reset_i,
  input  logic       load_start_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  input  logic [3:0] addr_i,
  output logic [7:0] data_o,
  output logic       cpu_n_reset_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned DEPTH = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] mem_q [DEPTH];

  logic       w_busy;
  logic       w_xfer;
  logic       w_we;
  logic [7:0] w_sum_next;

  assign w_busy     = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign w_xfer     = in_valid_i && w_busy;
  assign w_sum_next = sum_q + in_data_i;

  // Next-state logic. Bytes offered while not busy never form a transfer,
  // so they cannot disturb memory, sum or state.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    w_we     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start_i) begin
          state_d  = S_LOAD;
          wr_ptr_d = 4'd0;
          sum_d    = 8'd0;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_we     = 1'b1;
          sum_d    = w_sum_next;
          wr_ptr_d = wr_ptr_q + 4'd1;  // wraps to 0 after the last word
          if (wr_ptr_q == 4'd15) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        // Checksum byte is only summed, never stored.
        if (w_xfer) begin
          state_d = (w_sum_next == 8'd0) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= 4'd0;
      sum_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
    end
  end

  // Memory is flop-based so that reset can clear every word, including any
  // partially written image.
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (w_we) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  assign data_o        = mem_q[addr_i];
  assign in_ready_o    = w_busy;
  assign busy_o        = w_busy;
  assign done_o        = (state_q == S_DONE);
  assign err_o         = (state_q == S_ERR);
  assign cpu_n_reset_o = !(w_busy || (state_q == S_ERR));

endmodule
`default_nettype wire

// File: tb/tb_prog_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_ram_loader
// Purpose  : Self-checking bench for prog_ram_loader. A local memory model is
//            updated as bytes are streamed; expected read-back words are
//            queued when addresses are driven and popped when compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_ram_loader;

  logic       clk_i = 1'b0;
  logic       n_reset_i;
  logic       load_start_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic [3:0] addr_i;
  logic [7:0] data_o;
  logic       cpu_n_reset_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_mem [16];
  logic [7:0] sb_q [$];

  logic [7:0] img_nom [17];
  logic [7:0] img_bad [17];
  logic [7:0] img_one [17];

  always #5 clk_i = ~clk_i;

  prog_ram_loader u_dut (
    .clk_i         (clk_i),
    .n_reset_i     (n_reset_i),
    .load_start_i  (load_start_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_ready_o    (in_ready_o),
    .addr_i        (addr_i),
    .data_o        (data_o),
    .cpu_n_reset_o (cpu_n_reset_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic busy, input logic done,
                            input logic err, input logic cpu_nrst);
    chk({tag, ".busy"},     busy_o,        busy);
    chk({tag, ".in_ready"}, in_ready_o,    busy);
    chk({tag, ".done"},     done_o,        done);
    chk({tag, ".err"},      err_o,         err);
    chk({tag, ".cpu_nrst"}, cpu_n_reset_o, cpu_nrst);
  endtask

  // Read back every address against the model through the scoreboard queue.
  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      addr_i = a[3:0];
      sb_q.push_back(exp_mem[a]);
      #1;
      chk($sformatf("%s.mem[%0d]", tag, a), data_o, sb_q.pop_front());
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid_i = 1'b1;
    in_data_i  = b;
    #1;
    chk("xfer.in_ready", in_ready_o, 1'b1);
    tick();
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
  endtask

  task automatic load_image(input string tag, input logic [7:0] img [17],
                            input bit stall, input bit poke);
    logic [7:0] s;
    logic       ok;
    s = 8'h00;
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    chk_status({tag, ".start"}, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      send(img[i]);
      if (i < 16) begin
        exp_mem[i] = img[i];
        s = s + img[i];
      end
      if (stall && i < 16) begin
        for (int k = 0; k < 3; k++) begin
          // A start request during the load must be ignored.
          if (poke && i == 7 && k == 1) load_start_i = 1'b1;
          tick();
          load_start_i = 1'b0;
        end
        chk({tag, ".stall_busy"}, busy_o, 1'b1);
      end
    end
    ok = ((s + img[16]) == 8'h00);
    chk_status({tag, ".end"}, 1'b0, ok, !ok, ok);
    read_all(tag);
  endtask

  initial begin
    img_nom = '{8'h60, 8'h90, 8'h3D, 8'h01, 8'hE3, 8'h51, 8'hE1, 8'hB0,
                8'hBF, 8'hF7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h57};
    img_bad = img_nom;
    img_bad[16] = 8'h58;
    for (int i = 0; i < 16; i++) img_one[i] = 8'h01;
    img_one[16] = 8'hF0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

    n_reset_i    = 1'b0;
    load_start_i = 1'b0;
    in_valid_i   = 1'b0;
    in_data_i    = 8'h00;
    addr_i       = 4'd0;

    // Reset state
    #12;
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    read_all("rst");
    #10;
    n_reset_i = 1'b1;
    tick();

    // Bytes offered in IDLE are ignored
    in_valid_i = 1'b1;
    in_data_i  = 8'hFF;
    #1;
    chk("idle.in_ready", in_ready_o, 1'b0);
    tick(); tick(); tick();
    in_valid_i = 1'b0;
    chk_status("idle", 1'b0, 1'b0, 1'b0, 1'b1);
    read_all("idle");

    // Nominal load
    load_image("nom", img_nom, 1'b0, 1'b0);
    chk("nom.data4", exp_mem[4], 8'hE3);

    // Bad checksum from DONE
    load_image("bad", img_bad, 1'b0, 1'b0);

    // Bytes offered in ERR are ignored
    in_valid_i = 1'b1;
    in_data_i  = 8'hFF;
    tick(); tick();
    in_valid_i = 1'b0;
    chk_status("err_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    read_all("err_hold");

    // Stalled load with a spurious start request mid-load
    load_image("stall", img_nom, 1'b1, 1'b1);

    // Reload with all-ones image
    load_image("reload", img_one, 1'b0, 1'b0);

    // Asynchronous reset after the 5th byte
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(img_nom[i]);
      exp_mem[i] = img_nom[i];
    end
    #2;
    n_reset_i = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    chk_status("arst", 1'b0, 1'b0, 1'b0, 1'b1);
    read_all("arst");
    tick(); tick();
    #3;
    n_reset_i = 1'b1;
    tick();
    load_image("post_rst", img_nom, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a hung simulation.
  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/prog_ram_loader.md
PROG_RAM_LOADER -- requirements
Module: prog_ram_loader

Interface
REQ-001 Parameters: none; fixed at 16 words x 8 bits; 16 program bytes plus 1 checksum byte per image.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_reset  input  1  asynchronous active-low reset.
REQ-005 load_start  input  1  one-cycle request to begin loading a new image.
REQ-006 in_valid  input  1  in_data carries a valid byte this cycle.
REQ-007 in_data  input  8  image byte; program words in address order 0..15, then checksum.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid AND in_ready.
REQ-009 addr  input  4  CPU instruction-fetch address.
REQ-010 data  output  8  instruction word at addr.
REQ-011 cpu_n_reset  output  1  active-low hold for the CPU; low while an image is incomplete or rejected.
REQ-012 busy  output  1  high in LOAD and CHECK.
REQ-013 done  output  1  high in DONE (image accepted).
REQ-014 err  output  1  high in ERR (checksum mismatch).

Function
REQ-015 States: IDLE, LOAD, CHECK, DONE, ERR; state, wr_ptr (4 bits), sum (8 bits), 16x8 memory all registered.
REQ-016 All outputs except data decode registered state only: in_ready = busy = (LOAD or CHECK); done = DONE; err = ERR; cpu_n_reset = 0 in LOAD, CHECK, ERR, else 1.
REQ-017 data = mem[addr], combinational, no latency; a write lands at the clock edge and is visible on data the same cycle after that edge.
REQ-018 IDLE/DONE/ERR + load_start=1 -> LOAD next cycle; wr_ptr<=0, sum<=0; done/err drop in that cycle.
REQ-019 load_start in LOAD or CHECK is ignored; no restart, no effect on wr_ptr or sum.
REQ-020 LOAD, transfer: mem[wr_ptr]<=in_data, sum<=(sum+in_data) mod 256, wr_ptr<=wr_ptr+1.
REQ-021 LOAD, transfer with wr_ptr=15 -> CHECK; wr_ptr wraps to 0; no further memory write until next LOAD.
REQ-022 LOAD/CHECK, in_valid=0: hold state; stalls of any length allowed; no timeout.
REQ-023 CHECK, transfer: (sum+in_data) mod 256 = 0 -> DONE, else -> ERR; checksum byte never written to memory.
REQ-024 in_valid while in_ready=0 (IDLE/DONE/ERR) ignored; memory, sum, state unchanged.
REQ-025 ERR retains partially validated contents; CPU held in reset until a later load reaches DONE.
REQ-026 Memory writes only via REQ-020; no other path modifies contents after reset.

Reset
REQ-027 n_reset=0, asynchronously regardless of clk: state=IDLE, wr_ptr=0, sum=0, all 16 words=8'h00.
REQ-028 Outputs during/after reset: in_ready=0, busy=0, done=0, err=0, cpu_n_reset=1; data=8'h00 for any addr.
REQ-029 Reset mid-LOAD or mid-CHECK aborts the image: full REQ-027 values; partially written words cleared.
REQ-030 First clk edge after n_reset release: normal operation; load_start on that edge honoured.

Verification
REQ-031 Nominal load: after reset, pulse load_start; stream 60,90,3D,01,E3,51,E1,B0,BF,F7, six 00, checksum 57 back-to-back -> busy for 17 transfer cycles, then done=1, cpu_n_reset=1, err=0; addr 0..9 read 60,90,3D,01,E3,51,E1,B0,BF,F7; addr 10..15 read 00.
REQ-032 Bad checksum: same image, checksum 58 -> err=1, done=0, cpu_n_reset=0; addr 4 reads E3.
REQ-033 Stalls/ignored inputs: same image with in_valid low 3 cycles between bytes, load_start pulsed mid-LOAD, in_valid=1/in_data=FF in IDLE -> identical result to REQ-031; FF never stored.
REQ-034 Reset mid-load: n_reset low after 5th byte, asynchronously between edges -> outputs at reset values immediately; addr 0..4 read 00; fresh load then passes as REQ-031.
REQ-035 Reload: after DONE, load 16 bytes of 01 plus checksum F0 -> done drops 1 cycle after load_start, cpu_n_reset low during load, then done=1; all addresses read 01.
